es_and_alu_sub1_b: RTL and testbench
====================================

Name: es_and_alu_sub1_b

Overview:
- Datapath slice of the stack processor: an expression stack (ES) of 16-bit words, two operand registers (A, B) loaded from the stack top, and a combinational ALU over A/B.
- The ALU result can be pushed back onto the ES, closing the push/pop/compute/push loop used by arithmetic instructions.
- Control inputs come from the main control unit one cycle at a time.

Parameters:
- WIDTH, 16, data word width (ports are fixed at 16; must stay 16).
- DEPTH, 16, number of ES entries; power of two, at least 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ESOp  input  2  stack operation: 00 push, 01 pop, 10 dup, 11 swap (see Optional Feature).
- ESAct  input  1  stack action enable; 0 means stack, sp, A and B all hold.
- dupAmt  input  2  dup source depth: 0 = top, 3 = fourth entry.
- popAmt  input  1  pop count minus one: 0 pops 1 entry, 1 pops 2 entries.
- ALUOp  input  2  00 pass A, 01 A+B, 10 B-A, 11 A AND B.
- valIn  input  16  external push value.
- stackSrc  input  1  push source: 0 selects valIn, 1 selects ALUOut.
- ALUOut  output  16  combinational ALU result.
- zero_out  output  1  high when ALUOut == 0.
- ovflw_out  output  1  signed two's-complement overflow of the add/sub; 0 for pass and AND.

Behaviour:
- State: stack array[DEPTH] of 16 bits, stack pointer sp (0..DEPTH, count of valid entries), registers A and B. Top of stack is entry sp-1.
- Reset (asynchronous): sp=0, all entries=0, A=0, B=0.
  - With ALUOp=00 after reset: ALUOut=0, zero_out=1, ovflw_out=0.
- ESAct=0: no state change; ALUOut keeps tracking A/B/ALUOp combinationally.
- Push (ESAct=1, ESOp=00): entry[sp] <= (stackSrc ? ALUOut : valIn); sp <= sp+1.
  - ALUOut is sampled pre-edge (from current A/B).
  - If sp==DEPTH, the push is ignored (no wrap).
  - A and B hold.
- Pop (ESAct=1, ESOp=01):
  - A <= top.
  - If popAmt=1, B <= second entry; if popAmt=0, B holds.
  - sp <= sp-(popAmt+1), clamped at 0.
  - Any missing entry (stack under-full) loads 0 into its register.
  - Popped entries are not cleared.
- Dup (ESAct=1, ESOp=10): pushes a copy of entry[sp-1-dupAmt].
  - If dupAmt >= sp, pushes 0.
  - If sp==DEPTH, ignored.
  - A and B hold.
- Swap: see Optional Feature. A and B hold.
- Simultaneous reset and any operation: reset wins.
- ALU (purely combinational, no latency):
  - add and sub are modulo 2^16.
  - Overflow: add overflows when the operand signs are equal and the result sign differs; sub (B-A) overflows when the operand signs differ and the result sign differs from B.
- Latency:
  - Values pushed are visible in the stack on the next edge.
  - A/B are updated on the pop edge, so ALUOut for those operands is valid in the same cycle after that edge.
  - A push of ALUOut the following cycle captures that result.

Optional Feature:
- Macro ES_SWAP_EN.
- Defined: ESOp=11 with ESAct=1 exchanges the top two entries. sp is unchanged; the operation is ignored if sp<2.
- Undefined: ESOp=11 is a no-op (state holds).

Test Plan:
- Reset asserted mid-run with sp=3 and A=5: outputs drop immediately, without waiting for a clock edge, to sp=0, A=B=0, ALUOut=0, zero_out=1.
- Add round trip:
  - Steps: push valIn=1; push valIn=2; pop with popAmt=1 (A=2, B=1); ALUOp=01 with ESAct=0; push with stackSrc=1; pop with popAmt=0.
  - Required: ALUOut=3 before the final pop; A=3 after it; sp=0 at the end.
- Sub/overflow:
  - Push 0x8000 then 0x0001, pop 2, ALUOp=10 -> ALUOut=0x7FFF, ovflw_out=1.
  - Push 0x7FFF then 0x0001, pop 2, ALUOp=01 -> ALUOut=0x8000, ovflw_out=1.
  - ALUOp=11 -> ALUOut=0x0001, ovflw_out=0.
- Dup:
  - Push 10, 20, 30; dup with dupAmt=2; pop 1 -> A=10, sp=3.
  - Dup with dupAmt=3 when sp=3 -> pushes 0.
- Boundaries:
  - Push DEPTH+1 values -> last push ignored, sp=DEPTH, and the top still holds value DEPTH.
  - Pop 2 with sp=1 -> A=top, B=0, sp=0.
  - ESAct=0 with ESOp=00 -> no state change.
- Swap: push 4 then 9, ESOp=11, pop 2 -> with ES_SWAP_EN, A=4 and B=9; without it, A=9 and B=4.

Source files
------------

// File: rtl/es_and_alu_sub1_b.sv
// es_and_alu_sub1_b: expression stack, A/B operand registers and a
// combinational ALU. Every ESAct=1 cycle performs exactly one stack
// operation on the rising clock edge; ESAct=0 holds all state.
// Build option: define ES_SWAP_EN to make ESOp=11 swap the top two entries;
// without it ESOp=11 is a no-op.
module es_and_alu_sub1_b #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ESOp,
  input  logic              ESAct,
  input  logic [1:0]        dupAmt,
  input  logic              popAmt,
  input  logic [1:0]        ALUOp,
  input  logic [WIDTH-1:0]  valIn,
  input  logic              stackSrc,
  output logic [WIDTH-1:0]  ALUOut,
  output logic              zero_out,
  output logic              ovflw_out
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_DUP  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  // sp counts valid entries (0..DEPTH); the top of stack is entry sp-1.
  logic [WIDTH-1:0] stack [DEPTH];
  logic [SPW-1:0]   sp;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  logic             full;
  logic [SPW-1:0]   top_idx;
  logic [SPW-1:0]   sec_idx;
  logic [SPW-1:0]   dup_idx;
  logic [SPW-1:0]   dup_amt_w;
  logic [SPW-1:0]   pop_cnt;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] sec_val;
  logic [WIDTH-1:0] dup_val;
  logic [WIDTH-1:0] push_val;
  logic [SPW-1:0]   sp_after_pop;

  // ALU: pass A, A+B, B-A, A AND B; overflow only meaningful for add/sub.
  always_comb begin
    sum       = a_q + b_q;
    diff      = b_q - a_q;
    ALUOut    = a_q;
    ovflw_out = 1'b0;
    case (ALUOp)
      2'b00: ALUOut = a_q;
      2'b01: begin
        ALUOut    = sum;
        ovflw_out = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      2'b10: begin
        ALUOut    = diff;
        ovflw_out = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != b_q[WIDTH-1]);
      end
      default: ALUOut = a_q & b_q;
    endcase
    zero_out = (ALUOut == '0);
  end

  // Stack addressing helpers; reads of missing entries yield zero.
  always_comb begin
    full         = (sp == SP_FULL);
    top_idx      = sp - SP_ONE;
    sec_idx      = sp - SP_TWO;
    dup_amt_w    = {{(SPW-2){1'b0}}, dupAmt};
    dup_idx      = sp - SP_ONE - dup_amt_w;
    pop_cnt      = {{(SPW-1){1'b0}}, popAmt} + SP_ONE;
    top_val      = (sp >= SP_ONE) ? stack[top_idx[IW-1:0]] : '0;
    sec_val      = (sp >= SP_TWO) ? stack[sec_idx[IW-1:0]] : '0;
    dup_val      = (dup_amt_w < sp) ? stack[dup_idx[IW-1:0]] : '0;
    push_val     = stackSrc ? ALUOut : valIn;
    sp_after_pop = (sp >= pop_cnt) ? (sp - pop_cnt) : '0;
  end

  // Stack, stack pointer and operand registers; reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= '0;
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (ESAct) begin
      case (ESOp)
        OP_PUSH: begin
          if (!full) begin
            stack[sp[IW-1:0]] <= push_val;
            sp                <= sp + SP_ONE;
          end
        end
        OP_POP: begin
          a_q <= top_val;
          if (popAmt) begin
            b_q <= sec_val;
          end
          sp <= sp_after_pop;
        end
        OP_DUP: begin
          if (!full) begin
            stack[sp[IW-1:0]] <= dup_val;
            sp                <= sp + SP_ONE;
          end
        end
        OP_SWAP: begin
`ifdef ES_SWAP_EN
          if (sp >= SP_TWO) begin
            stack[top_idx[IW-1:0]] <= sec_val;
            stack[sec_idx[IW-1:0]] <= top_val;
          end
`else
          // Swap not built: state holds.
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_es_and_alu_sub1_b.sv
// tb_es_and_alu_sub1_b: directed vectors for the expression stack and ALU.
// Internal state (sp, A, B, stack entries) is observed hierarchically.
module tb_es_and_alu_sub1_b;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic [1:0]  ESOp;
  logic        ESAct;
  logic [1:0]  dupAmt;
  logic        popAmt;
  logic [1:0]  ALUOp;
  logic [15:0] valIn;
  logic        stackSrc;
  logic [15:0] ALUOut;
  logic        zero_out;
  logic        ovflw_out;

  int checks;
  int errors;

  es_and_alu_sub1_b #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .ESOp     (ESOp),
    .ESAct    (ESAct),
    .dupAmt   (dupAmt),
    .popAmt   (popAmt),
    .ALUOp    (ALUOp),
    .valIn    (valIn),
    .stackSrc (stackSrc),
    .ALUOut   (ALUOut),
    .zero_out (zero_out),
    .ovflw_out(ovflw_out)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: one stack operation, inputs settle 1 time unit after a rising edge.
  task automatic do_op(input logic [1:0] op, input logic [1:0] damt, input logic pamt,
                       input logic src, input logic [15:0] val);
    ESOp     = op;
    dupAmt   = damt;
    popAmt   = pamt;
    stackSrc = src;
    valIn    = val;
    ESAct    = 1'b1;
    @(posedge clk);
    #1;
    ESAct    = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    do_op(2'b00, 2'd0, 1'b0, 1'b0, v);
  endtask

  task automatic push_alu();
    do_op(2'b00, 2'd0, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic pop(input logic pamt);
    do_op(2'b01, 2'd0, pamt, 1'b0, 16'h0000);
  endtask

  task automatic dup(input logic [1:0] damt);
    do_op(2'b10, damt, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic idle();
    ESAct = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    ESOp     = 2'b00;
    ESAct    = 1'b0;
    dupAmt   = 2'd0;
    popAmt   = 1'b0;
    ALUOp    = 2'b00;
    valIn    = 16'h0000;
    stackSrc = 1'b0;

    // Reset state
    #12;
    check("rst_sp", dut.sp, 0);
    check("rst_a", dut.a_q, 0);
    check("rst_b", dut.b_q, 0);
    check("rst_aluout", ALUOut, 0);
    check("rst_zero", zero_out, 1);
    check("rst_ovf", ovflw_out, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-run with sp=3, A=5
    push(16'd5);
    pop(1'b0);
    push(16'd1);
    push(16'd2);
    push(16'd3);
    check("pre_async_sp", dut.sp, 3);
    check("pre_async_a", ALUOut, 5);
    #2 reset = 1'b1;
    #1;
    check("async_sp", dut.sp, 0);
    check("async_a", dut.a_q, 0);
    check("async_b", dut.b_q, 0);
    check("async_aluout", ALUOut, 0);
    check("async_zero", zero_out, 1);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Add round trip
    push(16'd1);
    push(16'd2);
    pop(1'b1);
    check("add_pop_a", dut.a_q, 2);
    check("add_pop_b", dut.b_q, 1);
    check("add_pop_sp", dut.sp, 0);
    ALUOp = 2'b01;
    idle();
    check("add_aluout", ALUOut, 3);
    check("add_ovf", ovflw_out, 0);
    push_alu();
    check("add_push_entry", dut.stack[0], 3);
    check("add_aluout_before_pop", ALUOut, 3);
    pop(1'b0);
    check("add_final_a", dut.a_q, 3);
    check("add_final_sp", dut.sp, 0);

    // Sub with overflow: B=0x8000, A=0x0001
    push(16'h8000);
    push(16'h0001);
    pop(1'b1);
    ALUOp = 2'b10;
    #1;
    check("sub_aluout", ALUOut, 16'h7FFF);
    check("sub_ovf", ovflw_out, 1);
    // Add with overflow: B=0x7FFF, A=0x0001
    push(16'h7FFF);
    push(16'h0001);
    pop(1'b1);
    ALUOp = 2'b01;
    #1;
    check("addov_aluout", ALUOut, 16'h8000);
    check("addov_ovf", ovflw_out, 1);
    ALUOp = 2'b11;
    #1;
    check("and_aluout", ALUOut, 16'h0001);
    check("and_ovf", ovflw_out, 0);
    check("and_zero", zero_out, 0);
    ALUOp = 2'b00;

    // Dup
    push(16'd10);
    push(16'd20);
    push(16'd30);
    dup(2'd2);
    check("dup_sp", dut.sp, 4);
    check("dup_entry", dut.stack[3], 10);
    pop(1'b0);
    check("dup_pop_a", dut.a_q, 10);
    check("dup_pop_sp", dut.sp, 3);
    dup(2'd3);
    check("dup_deep_entry", dut.stack[3], 0);
    check("dup_deep_sp", dut.sp, 4);

    // Full stack: DEPTH+1 pushes, last ignored
    pulse_reset();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      push(16'(i));
    end
    check("full_sp", dut.sp, DEPTH);
    check("full_top", dut.stack[DEPTH-1], DEPTH);
    pop(1'b0);
    check("full_pop_a", dut.a_q, DEPTH);
    // Drain pairs down to sp=1
    for (int i = 0; i < (DEPTH - 2) / 2; i++) begin
      pop(1'b1);
    end
    check("drain_sp", dut.sp, 1);
    check("drain_a", dut.a_q, 3);
    check("drain_b", dut.b_q, 2);
    pop(1'b1);
    check("underfull_a", dut.a_q, 1);
    check("underfull_b", dut.b_q, 0);
    check("underfull_sp", dut.sp, 0);

    // ESAct=0 with ESOp=00 holds state
    ESOp  = 2'b00;
    valIn = 16'hAAAA;
    ESAct = 1'b0;
    @(posedge clk);
    #1;
    check("hold_sp", dut.sp, 0);
    check("hold_entry", dut.stack[0], 1);
    check("hold_a", dut.a_q, 1);

    // Empty pop loads zero
    pop(1'b0);
    check("empty_pop_a", dut.a_q, 0);
    check("empty_pop_sp", dut.sp, 0);

    // Swap
    push(16'd4);
    push(16'd9);
    do_op(2'b11, 2'd0, 1'b0, 1'b0, 16'h0000);
    check("swap_sp", dut.sp, 2);
    pop(1'b1);
`ifdef ES_SWAP_EN
    check("swap_a", dut.a_q, 4);
    check("swap_b", dut.b_q, 9);
`else
    check("swap_a", dut.a_q, 9);
    check("swap_b", dut.b_q, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
